// File: rtl/conway_pkg.sv
// Shared types for the generation-rate and display timing path.
package conway_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } countdown_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, combinational borrow and registered done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the period at terminal count instead of stopping.
//
// state | meaning
// IDLE  | no countdown in progress, count is 0, loads accepted
// RUN   | counting down on enable ticks, count >= 1
module countdown_timer
    import conway_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_borrow,
    output logic             o_done
);

    countdown_state_t r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             w_load_ok_state;
    logic             w_xfer;
    logic             w_terminal;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
    assign w_load_ok_state = 1'b1;
`else
    assign w_load_ok_state = (r_state == IDLE);
`endif

    assign o_load_ready = w_load_ok_state && !i_abort && !i_reset;
    assign w_xfer       = i_load_valid && o_load_ready;
    assign w_terminal   = (r_state == RUN) && i_enable && (r_count == WIDTH'(1));
    assign o_borrow     = w_terminal;
    assign o_count      = r_count;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (i_load_value != '0) begin
                            r_count <= i_load_value;
                            r_state <= RUN;
                            r_busy  <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            r_reload <= i_load_value;
`endif
                        end else begin
                            // zero-length period completes immediately
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        r_count <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (w_xfer) begin
                            r_reload <= i_load_value;
                        end
                        // a load on the terminal cycle applies to the period after next
                        if (w_terminal) begin
                            r_done  <= 1'b1;
                            r_count <= r_reload;
                            if (r_reload == '0) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else if (i_enable) begin
                            r_count <= r_count - WIDTH'(1);
                        end
`else
                        if (w_terminal) begin
                            r_done  <= 1'b1;
                            r_count <= '0;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (i_enable) begin
                            r_count <= r_count - WIDTH'(1);
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; auto-reload vectors run when COUNTDOWN_AUTO_RELOAD_EN is defined.
module tb_countdown_timer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_load_valid;
    logic       o_load_ready;
    logic [7:0] i_load_value;
    logic       i_enable;
    logic       i_abort;
    logic [7:0] o_count;
    logic       o_busy;
    logic       o_borrow;
    logic       o_done;

    int n_vec = 0;
    int n_err = 0;

    countdown_timer #(.WIDTH(8)) u_dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load_valid (i_load_valid),
        .o_load_ready (o_load_ready),
        .i_load_value (i_load_value),
        .i_enable     (i_enable),
        .i_abort      (i_abort),
        .o_count      (o_count),
        .o_busy       (o_busy),
        .o_borrow     (o_borrow),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset      = 1'b1;
        i_load_valid = 1'b0;
        i_load_value = '0;
        i_enable     = 1'b0;
        i_abort      = 1'b0;
        tick();
        tick();
        check("rst_count", o_count, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_borrow", o_borrow, 0);
        check("rst_ready", o_load_ready, 0);
        i_reset = 1'b0;
        #1;
        check("post_rst_ready", o_load_ready, 1);

        // load 5 with enable held high
        i_load_valid = 1'b1;
        i_load_value = 8'd5;
        i_enable     = 1'b1;
        tick();
        i_load_valid = 1'b0;
        for (int c = 5; c >= 1; c--) begin
            #1;
            check("l5_count", o_count, c);
            check("l5_borrow", o_borrow, (c == 1));
            check("l5_busy", o_busy, 1);
            check("l5_done", o_done, 0);
            tick();
        end
        check("l5_end_count", o_count, 0);
        check("l5_end_done", o_done, 1);
        check("l5_end_busy", o_busy, 0);
        tick();
        check("l5_done_fall", o_done, 0);

        // zero-length load
        i_enable     = 1'b0;
        i_load_valid = 1'b1;
        i_load_value = 8'd0;
        #1;
        check("z_ready", o_load_ready, 1);
        tick();
        i_load_valid = 1'b0;
        check("z_busy", o_busy, 0);
        check("z_count", o_count, 0);
        check("z_done", o_done, 1);
        tick();
        check("z_done_fall", o_done, 0);

        // load 10, enable every other cycle, abort at 4
        i_load_valid = 1'b1;
        i_load_value = 8'd10;
        tick();
        i_load_valid = 1'b0;
        check("a_load", o_count, 10);
        for (int i = 0; i <= 10; i++) begin
            i_enable = (i % 2 == 0);
            tick();
            check("a_count", o_count, 10 - (i / 2) - 1);
        end
        i_enable = 1'b1;
        i_abort  = 1'b1;
        #1;
        check("a_ready_low", o_load_ready, 0);
        check("a_borrow", o_borrow, 0);
        tick();
        check("a_count0", o_count, 0);
        check("a_busy", o_busy, 0);
        check("a_no_done", o_done, 0);
        i_abort = 1'b0;
        #1;
        check("a_ready_high", o_load_ready, 1);
        tick();
        check("a_no_done2", o_done, 0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // load held off during one-shot RUN
        i_load_valid = 1'b1;
        i_load_value = 8'd3;
        i_enable     = 1'b1;
        tick();
        i_load_value = 8'd7;
        check("h_count3", o_count, 3);
        #1;
        check("h_ready_run", o_load_ready, 0);
        tick();
        check("h_count2", o_count, 2);
        tick();
        check("h_count1", o_count, 1);
        check("h_borrow", o_borrow, 1);
        tick();
        check("h_count0", o_count, 0);
        check("h_done", o_done, 1);
        check("h_ready_done", o_load_ready, 1);
        tick();
        i_load_valid = 1'b0;
        check("h_count7", o_count, 7);
        check("h_busy", o_busy, 1);
        check("h_done_fall", o_done, 0);
`else
        // auto-reload: load 3, reload 2 mid-period
        i_load_valid = 1'b1;
        i_load_value = 8'd3;
        i_enable     = 1'b1;
        tick();
        check("r_count3", o_count, 3);
        i_load_value = 8'd2;
        #1;
        check("r_ready_run", o_load_ready, 1);
        tick();
        i_load_valid = 1'b0;
        check("r_count2", o_count, 2);
        tick();
        check("r_count1", o_count, 1);
        check("r_borrow", o_borrow, 1);
        tick();
        check("r_reload2", o_count, 2);
        check("r_done1", o_done, 1);
        check("r_busy", o_busy, 1);
        tick();
        check("r_count1b", o_count, 1);
        check("r_done_fall", o_done, 0);
        tick();
        check("r_reload2b", o_count, 2);
        check("r_done2", o_done, 1);
`endif
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("clean_busy", o_busy, 0);

        // reset at count 6 of a 9-period countdown
        i_load_valid = 1'b1;
        i_load_value = 8'd9;
        i_enable     = 1'b1;
        tick();
        i_load_valid = 1'b0;
        tick();
        tick();
        tick();
        check("rs_count6", o_count, 6);
        i_reset = 1'b1;
        #1;
        check("rs_ready_low", o_load_ready, 0);
        tick();
        check("rs_count0", o_count, 0);
        check("rs_busy", o_busy, 0);
        check("rs_no_done", o_done, 0);
        i_reset = 1'b0;
        #1;
        check("rs_ready_high", o_load_ready, 1);
        tick();
        check("rs_no_done2", o_done, 0);
        check("rs_idle_count", o_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
